fifo_sync_ctrl: RTL and testbench
=================================

Name: fifo_sync_ctrl

Overview:
- Single-clock FIFO: storage array plus pointer/level control, status flags, programmable thresholds and sticky error flags.
- Parametrised successor of the TX FIFO memory. It adds internal pointer management, occupancy tracking, flush, simultaneous read/write handling and an optional registered read port.
- Sits between the register interface and the I2C shift engine on both the TX and RX paths.

Parameters:
- DATASIZE, 8, data word width in bits.
- ADDRSIZE, 4, address width; DEPTH = 1 << ADDRSIZE entries.
- AFULL_THR, DEPTH-2, almost_full_o asserts when level_o >= AFULL_THR.
- AEMPTY_THR, 2, almost_empty_o asserts when level_o <= AEMPTY_THR.

Ports:
- clk_i  input  1  system clock; all logic on its rising edge.
- rst_i  input  1  synchronous reset, active-high.
- flush_i  input  1  synchronous flush: empties FIFO and clears error flags.
- wr_en_i  input  1  write request.
- wdata_i  input  DATASIZE  write data.
- rd_en_i  input  1  read request (pop).
- rdata_o  output  DATASIZE  read data.
- full_o  output  1  level_o == DEPTH.
- empty_o  output  1  level_o == 0.
- almost_full_o  output  1  level_o >= AFULL_THR.
- almost_empty_o  output  1  level_o <= AEMPTY_THR.
- level_o  output  ADDRSIZE+1  current occupancy, 0..DEPTH.
- overflow_o  output  1  sticky: write attempted while full and not accepted.
- underflow_o  output  1  sticky: read attempted while empty.

Behaviour:
- Reset (rst_i=1 at clk edge):
  - wptr, rptr and level cleared to 0.
  - empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0, level_o=0.
  - overflow_o=0, underflow_o=0, rdata_o=0.
  - Memory contents are not reset.
- Priority at each edge: rst_i > flush_i > rd/wr.
  - Flush has the same effect as reset except rdata_o holds its value.
  - Requests in a reset or flush cycle are ignored and do not set error flags.
- Pointers are ADDRSIZE bits and wrap naturally from DEPTH-1 to 0.
- Write acceptance: wr_acc = wr_en_i & (!full_o | rd_acc).
  - On acceptance, mem[wptr] <= wdata_i and wptr increments.
- Read acceptance: rd_acc = rd_en_i & !empty_o; on acceptance rptr increments.
- Level update:
  - +1 on write only; -1 on read only.
  - Unchanged when both are accepted, or when neither is.
- Full and both requested: both accepted; level stays DEPTH; full_o stays 1.
- Empty and both requested: write accepted, read rejected; level becomes 1; underflow_o set.
- Error flags:
  - overflow_o sets on wr_en_i & !wr_acc.
  - underflow_o sets on rd_en_i & empty_o.
  - Both hold until reset or flush.
- Status flags and level_o are registered. They reflect the accepted operations one cycle after the edge on which those operations occur.
- Read data (macro undefined): show-ahead.
  - rdata_o = mem[rptr], combinational.
  - Valid whenever empty_o=0; value undefined-but-stable while empty.
- Write-to-read latency: a word written into an empty FIFO is visible on rdata_o the cycle after the write edge, when empty_o deasserts.
- Thresholds are compile-time only. AFULL_THR must be in 1..DEPTH and AEMPTY_THR in 0..DEPTH-1; out-of-range values are unsupported.

Optional Feature:
- Macro: FIFO_REG_OUT_EN.
- Defined: rdata_o is a register.
  - On rd_acc, rdata_o <= mem[rptr] at that edge, so data appears one cycle after the pop request.
  - Otherwise rdata_o holds its value; reset to 0.
  - Flags, level and all acceptance rules are unchanged.
- Undefined: show-ahead combinational read as described in Behaviour.

Test Plan:
- Reset then idle -> empty_o=1, almost_empty_o=1, level_o=0, overflow_o=0, underflow_o=0, rdata_o=0.
- Write 16 words 0x00..0x0F (defaults), then a 17th word 0xAA -> full_o=1, level_o=16, almost_full_o from level 14, overflow_o=1. Read all 16 words back in order 0x00..0x0F; 0xAA is never read.
- Fill to 16, then wr_en_i=rd_en_i=1 with 0x55 for 4 cycles -> level_o stays 16, no overflow. Drain yields 0x04..0x0F then 0x55 ×4, proving pointer wrap.
- From empty, wr_en_i=rd_en_i=1 with 0x3C in one cycle -> level_o=1, underflow_o=1, next read returns 0x3C.
- Write 5 words, assert flush_i together with wr_en_i -> level_o=0, empty_o=1, errors cleared, flush-cycle write dropped.
- With FIFO_REG_OUT_EN: write 0x11, 0x22; pulse rd_en_i -> rdata_o=0x11 one cycle after the pulse edge and holds until the next accepted read, which yields 0x22.

Source files
------------

// File: rtl/fifo_sync_ctrl.sv
// fifo_sync_ctrl
//   Single-clock FIFO: storage array, read/write pointers, occupancy level,
//   registered status flags, compile-time thresholds and sticky error flags.
//   Used on both the TX and RX paths between the register interface and the
//   I2C shift engine.
//
// Optional build macro:
//   FIFO_REG_OUT_EN  defined   -> rdata_o is a register, loaded on each
//                                 accepted pop (data one cycle after the pop).
//                    undefined -> show-ahead: rdata_o is the head word,
//                                 combinational, forced to 0 while empty.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          synchronous reset, active-high
//   flush_i        synchronous flush: empties FIFO, clears error flags
//   wr_en_i        write request
//   wdata_i        write data [DATASIZE]
//   rd_en_i        read (pop) request
//   rdata_o        read data [DATASIZE]
//   full_o         level_o == DEPTH
//   empty_o        level_o == 0
//   almost_full_o  level_o >= AFULL_THR
//   almost_empty_o level_o <= AEMPTY_THR
//   level_o        occupancy 0..DEPTH [ADDRSIZE+1]
//   overflow_o     sticky: write refused because full
//   underflow_o    sticky: read requested while empty
module fifo_sync_ctrl #(
  parameter int DATASIZE   = 8,
  parameter int ADDRSIZE   = 4,
  parameter int AFULL_THR  = (1 << ADDRSIZE) - 2,
  parameter int AEMPTY_THR = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                wr_en_i,
  input  logic [DATASIZE-1:0] wdata_i,
  input  logic                rd_en_i,
  output logic [DATASIZE-1:0] rdata_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                almost_full_o,
  output logic                almost_empty_o,
  output logic [ADDRSIZE:0]   level_o,
  output logic                overflow_o,
  output logic                underflow_o
);

  localparam int                DEPTH    = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] DEPTH_L  = (ADDRSIZE+1)'(DEPTH);
  localparam logic [ADDRSIZE:0] AFULL_L  = (ADDRSIZE+1)'(AFULL_THR);
  localparam logic [ADDRSIZE:0] AEMPTY_L = (ADDRSIZE+1)'(AEMPTY_THR);

  logic [DATASIZE-1:0] mem [DEPTH];

  logic [ADDRSIZE-1:0] wptr_q, wptr_d;
  logic [ADDRSIZE-1:0] rptr_q, rptr_d;
  logic [ADDRSIZE:0]   level_q, level_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                afull_q, afull_d;
  logic                aempty_q, aempty_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;

  logic                wr_acc, rd_acc, wr_go;

  always_comb begin
    // A pop frees a slot in the same edge, so a full FIFO can still take a write.
    rd_acc   = rd_en_i & ~empty_q;
    wr_acc   = wr_en_i & (~full_q | rd_acc);
    wr_go    = wr_acc & ~rst_i & ~flush_i;

    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + 1'b1;
      if (rd_acc) rptr_d = rptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (wr_en_i & ~wr_acc) ovf_d = 1'b1;
      if (rd_en_i & empty_q) udf_d = 1'b1;
    end

    // Flags are registered copies derived from the next level.
    full_d   = (level_d == DEPTH_L);
    empty_d  = (level_d == '0);
    afull_d  = (level_d >= AFULL_L);
    aempty_d = (level_d <= AEMPTY_L);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is never reset; only accepted writes outside reset/flush land.
  always_ff @(posedge clk_i) begin
    if (wr_go) mem[wptr_q] <= wdata_i;
  end

`ifdef FIFO_REG_OUT_EN
  logic [DATASIZE-1:0] rdata_q, rdata_d;
  logic                rd_go;

  // Flush holds the output word; only reset clears it.
  always_comb begin
    rd_go   = rd_acc & ~flush_i;
    rdata_d = rd_go ? mem[rptr_q] : rdata_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;
`else
  // Head word is shown directly; forced to 0 while empty so the output is
  // stable and defined after reset regardless of memory contents.
  assign rdata_o = empty_q ? '0 : mem[rptr_q];
`endif

  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign level_o        = level_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
module tb_fifo_sync_ctrl;

  localparam int DEPTH  = 16;
  localparam int AFULL  = DEPTH - 2;
  localparam int AEMPTY = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] rdata;
  logic       full, empty, afull, aempty, ovf, udf;
  logic [4:0] level;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;
  logic [7:0] m_rd  = 8'h00;

  fifo_sync_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .wr_en_i       (wr_en),
    .wdata_i       (wdata),
    .rd_en_i       (rd_en),
    .rdata_o       (rdata),
    .full_o        (full),
    .empty_o       (empty),
    .almost_full_o (afull),
    .almost_empty_o(aempty),
    .level_o       (level),
    .overflow_o    (ovf),
    .underflow_o   (udf)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, advance the model by the FIFO rules, then
  // leave the caller 1 time unit after the rising edge to sample outputs.
  task automatic drive(input logic r, input logic f, input logic w,
                       input logic [7:0] d, input logic rd);
    bit rok, wok;
    @(negedge clk);
    rst = r; flush = f; wr_en = w; wdata = d; rd_en = rd;
    @(posedge clk);
    if (r) begin
      mq.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_rd = 8'h00;
    end else if (f) begin
      mq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      rok = rd && (mq.size() > 0);
      wok = w && ((mq.size() < DEPTH) || rok);
      if (w && !wok) m_ovf = 1'b1;
      if (rd && mq.size() == 0) m_udf = 1'b1;
      if (rok) m_rd = mq.pop_front();
      if (wok) mq.push_back(d);
    end
    #1;
  endtask

  function automatic logic [7:0] exp_rdata();
`ifdef FIFO_REG_OUT_EN
    return m_rd;
`else
    return (mq.size() > 0) ? mq[0] : 8'h00;
`endif
  endfunction

  function automatic logic [18:0] exp_vec();
    int n = mq.size();
    return {n == DEPTH, n == 0, n >= AFULL, n <= AEMPTY, m_ovf, m_udf,
            5'(n), exp_rdata()};
  endfunction

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b1, 8'hEE, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b exp 1", empty); end
    n_vec++; if (aempty !== 1'b1) begin n_err++; $display("FAIL reset_aempty got %b exp 1", aempty); end
    n_vec++; if (full !== 1'b0 || afull !== 1'b0) begin n_err++; $display("FAIL reset_full got %b/%b exp 0/0", full, afull); end
    n_vec++; if (level !== 5'd0) begin n_err++; $display("FAIL reset_level got %0d exp 0", level); end
    n_vec++; if (ovf !== 1'b0 || udf !== 1'b0) begin n_err++; $display("FAIL reset_err got %b/%b exp 0/0", ovf, udf); end
    n_vec++; if (rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata got %h exp 00", rdata); end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] got;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b0, 1'b1, 8'(i), 1'b0);
      n_vec++; if (level !== 5'(i + 1)) begin n_err++; $display("FAIL fill_level got %0d exp %0d", level, i + 1); end
      n_vec++; if (afull !== (i + 1 >= AFULL)) begin n_err++; $display("FAIL fill_afull lvl %0d got %b", i + 1, afull); end
    end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL fill_noovf got %b exp 0", ovf); end
    drive(1'b0, 1'b0, 1'b1, 8'hAA, 1'b0);
    n_vec++; if (full !== 1'b1 || level !== 5'd16) begin n_err++; $display("FAIL ovf_full got %b/%0d exp 1/16", full, level); end
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b exp 1", ovf); end
    for (int i = 0; i < DEPTH; i++) begin
      got = rdata;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
`ifdef FIFO_REG_OUT_EN
      got = rdata;
`endif
      n_vec++; if (got !== 8'(i)) begin n_err++; $display("FAIL drain_data idx %0d got %h exp %h", i, got, 8'(i)); end
    end
    n_vec++; if (empty !== 1'b1 || udf !== 1'b0) begin n_err++; $display("FAIL drain_end got e%b u%b exp e1 u0", empty, udf); end
  endtask

  task automatic test_back_to_back_full();
    logic [7:0] got;
    logic [7:0] exp;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b0, 1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 8'h55, 1'b1);
      n_vec++; if (level !== 5'd16 || full !== 1'b1 || ovf !== 1'b0) begin
        n_err++; $display("FAIL b2b_full got lvl %0d f%b o%b exp 16 1 0", level, full, ovf);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      exp = (i < 12) ? 8'(i + 4) : 8'h55;
      got = rdata;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
`ifdef FIFO_REG_OUT_EN
      got = rdata;
`endif
      n_vec++; if (got !== exp) begin n_err++; $display("FAIL wrap_data idx %0d got %h exp %h", i, got, exp); end
    end
  endtask

  task automatic test_empty_rw();
    logic [7:0] got;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'h3C, 1'b1);
    n_vec++; if (level !== 5'd1 || empty !== 1'b0) begin n_err++; $display("FAIL erw_level got %0d e%b exp 1 e0", level, empty); end
    n_vec++; if (udf !== 1'b1) begin n_err++; $display("FAIL erw_udf got %b exp 1", udf); end
    got = rdata;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
`ifdef FIFO_REG_OUT_EN
    got = rdata;
`endif
    n_vec++; if (got !== 8'h3C) begin n_err++; $display("FAIL erw_data got %h exp 3c", got); end
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0);
    n_vec++; if (level !== 5'd5 || udf !== 1'b1) begin n_err++; $display("FAIL preflush got lvl %0d u%b exp 5 1", level, udf); end
    drive(1'b0, 1'b1, 1'b1, 8'h99, 1'b1);
    n_vec++; if (level !== 5'd0 || empty !== 1'b1 || aempty !== 1'b1) begin
      n_err++; $display("FAIL flush_state got lvl %0d e%b ae%b exp 0 1 1", level, empty, aempty);
    end
    n_vec++; if (udf !== 1'b0 || ovf !== 1'b0) begin n_err++; $display("FAIL flush_err got u%b o%b exp 0 0", udf, ovf); end
    drive(1'b0, 1'b0, 1'b1, 8'h77, 1'b0);
    n_vec++; if (level !== 5'd1) begin n_err++; $display("FAIL flush_drop got lvl %0d exp 1", level); end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
`ifdef FIFO_REG_OUT_EN
    n_vec++; if (rdata !== 8'h77) begin n_err++; $display("FAIL flush_next got %h exp 77", rdata); end
`endif
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL flush_next_empty got %b exp 1", empty); end
  endtask

`ifdef FIFO_REG_OUT_EN
  task automatic test_reg_out();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'h11, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'h22, 1'b0);
    n_vec++; if (rdata !== 8'h00) begin n_err++; $display("FAIL regout_pre got %h exp 00", rdata); end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    n_vec++; if (rdata !== 8'h11) begin n_err++; $display("FAIL regout_first got %h exp 11", rdata); end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    n_vec++; if (rdata !== 8'h11) begin n_err++; $display("FAIL regout_hold got %h exp 11", rdata); end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    n_vec++; if (rdata !== 8'h22) begin n_err++; $display("FAIL regout_second got %h exp 22", rdata); end
  endtask
`endif

  task automatic test_random();
    logic       r, f, w, rd;
    logic [7:0] d;
    logic [18:0] exp;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 1200; c++) begin
      // Alternate write-heavy and read-heavy phases to reach both ends.
      r  = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 79) == 0);
      w  = ((c / 150) % 2 == 0) ? ($urandom_range(0, 99) < 75) : ($urandom_range(0, 99) < 30);
      rd = ((c / 150) % 2 == 0) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 75);
      d  = 8'($urandom);
      drive(r, f, w, d, rd);
      exp = exp_vec();
      n_vec++;
      if ({full, empty, afull, aempty, ovf, udf, level, rdata} !== exp) begin
        n_err++;
        $display("FAIL random cyc %0d got f%b e%b af%b ae%b o%b u%b l%0d d%h exp %b",
                 c, full, empty, afull, aempty, ovf, udf, level, rdata, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_back_to_back_full();
    test_empty_rw();
    test_flush();
`ifdef FIFO_REG_OUT_EN
    test_reg_out();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
